vec_lsu_ctrl: RTL
=================

Name: vec_lsu_ctrl

Overview:
Sequencer for the vector load/store unit's element datapath. It accepts a load or store command from the vector processor controller and walks vl elements. For each element it computes the unit-stride or constant-stride address and issues one memory request per element with a req/ack handshake. It steers load data into the element buffer (or supplies store data from it) and reports completion to the controller. It sits between vector_processor_controller, main_memory and the LSU element buffer.

Parameters:
XLEN, 32, scalar address/data width
SEW, 32, element width in bits; unit stride = SEW/8 bytes
VLMAX, 16, maximum elements per instruction
CNT_W, $clog2(VLMAX+1), width of element count/index

Ports:
clk  in  1  clock, rising edge
n_rst  in  1  reset, synchronous, active-low
start  in  1  command strobe, sampled only in IDLE
is_store  in  1  1 = store, 0 = load; captured with start
stride_sel  in  1  1 = unit stride (SEW/8), 0 = constant stride rs2_data; captured with start
rs1_data  in  XLEN  base address; captured with start
rs2_data  in  XLEN  byte stride; captured with start
vl  in  CNT_W  element count; captured with start
mem_req  out  1  memory request valid
mem_we  out  1  1 = write request
mem_addr  out  XLEN  element address
mem_wdata  out  SEW  store data (= st_elem_data)
mem_ack  in  1  memory accepted request; load data valid this cycle
mem_rdata  in  SEW  load data
elem_idx  out  CNT_W  current element index into the LSU buffer
elem_we  out  1  load-data write strobe to the buffer
elem_wdata  out  SEW  load data to the buffer (= mem_rdata)
st_elem_data  in  SEW  buffer read data at elem_idx
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (n_rst=0 at a rising edge): state=IDLE; addr, stride, idx, vl_q and is_store_q all 0. Outputs mem_req, mem_we, mem_addr, elem_idx, elem_we, busy and done are 0.
- Reset mid-operation: same result; mem_req drops after that edge; no partial done pulse.
- States IDLE, ISSUE, DONE, held in lsu_state_e.
- IDLE with start=1:
  - Capture addr=rs1_data.
  - Capture stride = stride_sel ? SEW/8 : rs2_data.
  - Capture is_store and vl_q = min(vl, VLMAX). vl > VLMAX clamps.
  - Set idx=0.
  - Go to ISSUE, or to DONE if the clamped vl is 0. No memory traffic when vl is 0.
- ISSUE:
  - mem_req=1, mem_we=is_store_q, mem_addr=addr, elem_idx=idx.
  - mem_addr, mem_we and idx hold stable until mem_ack.
- ISSUE with mem_ack=1:
  - Load: elem_we=1 combinationally in the same cycle, elem_wdata=mem_rdata.
  - At the edge: addr += stride (mod 2^XLEN, wrap silently), idx += 1.
  - If idx == vl_q-1, go to DONE.
- ISSUE with mem_ack=0: hold all state. There is no timeout.
- mem_ack is ignored outside ISSUE. elem_we=0 outside ISSUE and for stores.
- DONE: done=1 for exactly one cycle, busy=1, mem_req=0. Next state is IDLE.
- start is ignored while busy. No queuing.
- Latency:
  - start sampled at edge 0 gives mem_req=1 in cycle 1.
  - With mem_ack held at 1, N elements occupy N ISSUE cycles.
  - done is asserted in cycle N+1 and busy falls in cycle N+2.
- The first element address is rs1_data, not rs1_data+stride.
- Stride is unsigned 2's-complement XLEN. Negative strides therefore walk downward naturally.

Decomposition:
- Shared package vec_lsu_pkg holds lsu_state_e (IDLE, ISSUE, DONE) and the constant UNIT_STRIDE = SEW/8. The CNT_W helper is derived there from VLMAX.
- One natural sub-module, vec_lsu_addr_gen: the address register, stride register and adder, with load/advance enables. The FSM, counter and handshake stay in vec_lsu_ctrl.

Test Plan:
- Unit-stride load: rs1=0x100, vl=4, stride_sel=1, mem_ack=1 every cycle, mem_rdata=0xA0..0xA3 → mem_addr 0x100/0x104/0x108/0x10C in cycles 1-4; elem_we with idx 0..3 and data 0xA0..0xA3; done in cycle 5 only.
- Strided store with stalls: rs1=0x2000, rs2=0x20, vl=3, ack delayed 2 cycles per element → mem_we=1; addresses 0x2000/0x2020/0x2040, each held stable through its stall; elem_we never asserted; one done pulse.
- Boundary vl: vl=0 → no mem_req, done one cycle after start. vl=20 → exactly 16 requests; last elem_idx=15.
- Wrap and negative stride: rs1=0xFFFFFFF8, stride_sel=1, vl=3 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000. rs2=0xFFFFFFFC from 0x10, vl=2 → 0x10, 0x0C.
- start while busy: second start with different rs1 during ISSUE → ignored; original sequence completes unchanged.
- Reset mid-op: n_rst=0 after 2 of 8 acks → next cycle IDLE, mem_req=0, busy=0, no done. A new start then begins at its own rs1 with idx=0.

Source files
------------

// File: rtl/vec_lsu_pkg.sv
// vec_lsu_pkg: shared types and constants for the vector LSU sequencer.
//   lsu_state_e   - sequencer states (idle, issuing elements, completion pulse)
//   cnt_w()       - width of an element count/index able to hold 0..vlmax
//   unit_stride() - byte distance between consecutive elements of width sew
package vec_lsu_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned SEW_DEF   = 32;
  localparam int unsigned VLMAX_DEF = 16;

  function automatic int unsigned cnt_w(input int unsigned vlmax);
    return $clog2(vlmax + 1);
  endfunction

  function automatic int unsigned unit_stride(input int unsigned sew);
    return sew / 8;
  endfunction

  localparam int unsigned CNT_W       = cnt_w(VLMAX_DEF);
  localparam int unsigned UNIT_STRIDE = unit_stride(SEW_DEF);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDone
  } lsu_state_e;

endpackage

// File: rtl/vec_lsu_addr_gen.sv
// vec_lsu_addr_gen: element address generator.
//   i_clk, i_n_rst     - clock, synchronous active-low reset
//   i_load             - capture i_base as address and i_stride as stride
//   i_advance          - step address by the stored stride (wraps mod 2^XLEN)
//   i_base, i_stride   - base address and byte stride for i_load
//   o_addr             - current element address
module vec_lsu_addr_gen
  import vec_lsu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            i_clk,
  input  logic            i_n_rst,
  input  logic            i_load,
  input  logic            i_advance,
  input  logic [XLEN-1:0] i_base,
  input  logic [XLEN-1:0] i_stride,
  output logic [XLEN-1:0] o_addr
);

  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_stride;

  always_ff @(posedge i_clk) begin
    if (!i_n_rst) begin
      r_addr   <= '0;
      r_stride <= '0;
    end else if (i_load) begin
      r_addr   <= i_base;
      r_stride <= i_stride;
    end else if (i_advance) begin
      // Negative strides are plain 2's-complement adds, so they walk downward.
      r_addr <= r_addr + r_stride;
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/vec_lsu_ctrl.sv
// vec_lsu_ctrl: vector load/store element sequencer.
//   i_clk, i_n_rst                       - clock, synchronous active-low reset
//   i_start, i_is_store, i_stride_sel    - command strobe and its attributes
//   i_rs1_data, i_rs2_data, i_vl         - base address, byte stride, element count
//   o_mem_req/we/addr/wdata, i_mem_ack,
//   i_mem_rdata                          - one memory request per element
//   o_elem_idx, o_elem_we, o_elem_wdata,
//   i_st_elem_data                       - element buffer access
//   o_busy, o_done                       - status to the controller
module vec_lsu_ctrl
  import vec_lsu_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned SEW   = SEW_DEF,
  parameter int unsigned VLMAX = VLMAX_DEF,
  parameter int unsigned CNT_W = cnt_w(VLMAX)
) (
  input  logic             i_clk,
  input  logic             i_n_rst,
  input  logic             i_start,
  input  logic             i_is_store,
  input  logic             i_stride_sel,
  input  logic [XLEN-1:0]  i_rs1_data,
  input  logic [XLEN-1:0]  i_rs2_data,
  input  logic [CNT_W-1:0] i_vl,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic [XLEN-1:0]  o_mem_addr,
  output logic [SEW-1:0]   o_mem_wdata,
  input  logic             i_mem_ack,
  input  logic [SEW-1:0]   i_mem_rdata,
  output logic [CNT_W-1:0] o_elem_idx,
  output logic             o_elem_we,
  output logic [SEW-1:0]   o_elem_wdata,
  input  logic [SEW-1:0]   i_st_elem_data,
  output logic             o_busy,
  output logic             o_done
);

  lsu_state_e       r_state;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_vl;
  logic             r_is_store;
  logic             r_mem_req;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W-1:0] w_vl_clamped;
  logic [XLEN-1:0]  w_stride_val;
  logic             w_load;
  logic             w_advance;
  logic             w_last;

  assign w_vl_clamped = (i_vl > CNT_W'(VLMAX)) ? CNT_W'(VLMAX) : i_vl;
  assign w_stride_val = i_stride_sel ? XLEN'(unit_stride(SEW)) : i_rs2_data;
  assign w_load       = (r_state == StIdle) && i_start;
  assign w_advance    = (r_state == StIssue) && i_mem_ack;
  assign w_last       = (r_idx == r_vl - CNT_W'(1));

  vec_lsu_addr_gen #(
    .XLEN (XLEN)
  ) u_addr_gen (
    .i_clk     (i_clk),
    .i_n_rst   (i_n_rst),
    .i_load    (w_load),
    .i_advance (w_advance),
    .i_base    (i_rs1_data),
    .i_stride  (w_stride_val),
    .o_addr    (o_mem_addr)
  );

  // Status outputs are registered alongside the state so they change only at edges.
  always_ff @(posedge i_clk) begin
    if (!i_n_rst) begin
      r_state    <= StIdle;
      r_idx      <= '0;
      r_vl       <= '0;
      r_is_store <= 1'b0;
      r_mem_req  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_is_store <= i_is_store;
            r_vl       <= w_vl_clamped;
            r_idx      <= '0;
            r_busy     <= 1'b1;
            if (w_vl_clamped == '0) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_state   <= StIssue;
              r_mem_req <= 1'b1;
            end
          end
        end
        StIssue: begin
          if (i_mem_ack) begin
            r_idx <= r_idx + CNT_W'(1);
            if (w_last) begin
              r_state   <= StDone;
              r_mem_req <= 1'b0;
              r_done    <= 1'b1;
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state   <= StIdle;
          r_mem_req <= 1'b0;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign o_mem_req    = r_mem_req;
  assign o_mem_we     = r_mem_req & r_is_store;
  assign o_mem_wdata  = i_st_elem_data;
  assign o_elem_idx   = r_idx;
  // Load data is written in the ack cycle itself; no extra buffering stage.
  assign o_elem_we    = r_mem_req & i_mem_ack & ~r_is_store;
  assign o_elem_wdata = i_mem_rdata;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule
